forth_mem_arbiter: RTL and testbench
====================================

// Module: forth_mem_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between three requesters:
//  - instruction fetch (IF)
//  - core data access (D), driven by the decoder's MemRead/MemWrite
//  - host loader/debug port (H)
//  Grants one access per cycle and returns read data one cycle later.
//  Drives stall to the core while its fetch or data request is denied.
//  Sits between the Forth core and the RAM macro.
// PARAMETERS
//  AW          13  address width; matches the 13-bit jump/jal/jz immediate
//  DW          16  data word width
//  STARVE_MAX  4   denied-fetch cycles before fetch is promoted (fair mode)
// PORTS
//  clk        in   1   single system clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  if_req     in   1   fetch read request
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   fetch granted this cycle
//  if_rvalid  out  1   rdata holds fetch result
//  d_req      in   1   data request
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  data write value
//  d_gnt      out  1   data granted this cycle
//  d_rvalid   out  1   rdata holds data read result
//  h_req      in   1   host request
//  h_we       in   1   1 = write, 0 = read
//  h_addr     in   AW  host address
//  h_wdata    in   DW  host write value
//  h_lock     in   1   keep host ownership after this grant
//  h_gnt      out  1   host granted this cycle
//  h_rvalid   out  1   rdata holds host read result
//  rdata      out  DW  shared read data = mem_rdata; qualified by *_rvalid
//  stall      out  1   (if_req & ~if_gnt) | (d_req & ~d_gnt)
//  mem_en     out  1   RAM enable
//  mem_we     out  1   RAM write enable
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  DW  RAM write data
//  mem_rdata  in   DW  RAM read data, valid 1 cycle after enabled read
// BEHAVIOUR
//  Grants:
//  - Combinational, same cycle as request; at most one *_gnt high.
//  - mem_* muxed from the granted requester; mem_en = |gnt.
//  - mem_en = 0 and mem_we = 0 when nothing is granted.
//  Priority: H > D > IF (fair-mode exception under CONFIGURATION).
//  FSM:
//  - ARB: normal priority arbitration.
//  - ARB -> LOCKED when h_gnt & h_lock.
//  - LOCKED: only H may be granted; if_gnt = d_gnt = 0.
//  - LOCKED -> ARB in the cycle h_lock is low; normal arbitration applies
//    in that same cycle.
//  Read return:
//  - *_rvalid registered: high exactly 1 cycle after a read grant (gnt & ~we).
//  - Writes produce no rvalid.
//  - Back-to-back reads give one rvalid per cycle, in grant order.
//  Reset (rst high, sampled at clk):
//  - state = ARB, rvalid flops = 0, starve counter = 0.
//  - All *_gnt = 0 and mem_en = 0 combinationally while rst is high.
//  - stall = if_req | d_req while rst is high.
//  - Reset mid-read: the next-cycle rvalid is suppressed.
//  - Reset while LOCKED returns to ARB.
//  Simultaneous events: an H read and a D write in the same cycle means
//  H is granted, D is stalled and re-presented unchanged by the core.
//  Requesters hold req/addr/data stable until granted.
// CONFIGURATION
//  Macro: FORTH_MEM_ARB_FAIR_EN
//  Defined:
//  - Counter of width $clog2(STARVE_MAX+1) counts cycles with
//    if_req & ~if_gnt, saturating at STARVE_MAX.
//  - Counter clears on if_gnt or ~if_req.
//  - At STARVE_MAX, in ARB, IF outranks D for one grant; H stays top.
//  Undefined: strict H > D > IF; no counter logic exists.
// TESTING
//  1. rst=1 with all reqs high -> all gnt=0, mem_en=0, stall=1;
//     first cycle after release -> h_gnt=1.
//  2. if_req, if_addr=0x0010, mem_rdata=0xABCD -> if_gnt same cycle;
//     next cycle if_rvalid=1, rdata=0xABCD.
//  3. if_req and d_req (read 0x0100) together -> d_gnt=1, stall=1;
//     next cycle, with d_req low -> if_gnt=1, stall=0.
//  4. h_req, h_lock=1 for 3 cycles, d_req held -> d_gnt=0 and stall=1
//     throughout; d_gnt=1 in the cycle h_lock falls.
//  5. d_req and if_req held continuously, STARVE_MAX=4 -> with
//     FORTH_MEM_ARB_FAIR_EN, if_gnt=1 on the 5th cycle, then D resumes;
//     without it, if_gnt never asserts.
//  6. d read granted at cycle N, rst=1 at cycle N+1 -> d_rvalid=0 at N+1;
//     state returns to ARB.

Source files
------------

// File: rtl/forth_mem_arbiter.sv
// Three-way arbiter (host, data, fetch) in front of the single-port RAM with a one-cycle read return.
// Optional fetch anti-starvation promotion is built when FORTH_MEM_ARB_FAIR_EN is defined.
module forth_mem_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Handshake: a requester holds req and its payload stable until it sees
    // its gnt high in the same cycle; read data follows as *_rvalid one cycle later.

    typedef enum logic {ARB, LOCKED} state_t;

    state_t state;
    logic   host_only;
    logic   if_first;
    logic   h_rv_q, d_rv_q, if_rv_q;

    // The lock only binds while the host keeps h_lock high; dropping it reopens arbitration at once.
    assign host_only = (state == LOCKED) && h_lock;

`ifdef FORTH_MEM_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;

    assign if_first = (starve_cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (!if_first) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign if_first = 1'b0 && (STARVE_MAX > 0);
`endif

    always_comb begin
        h_gnt  = 1'b0;
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            if (h_req) begin
                h_gnt = 1'b1;
            end else if (!host_only) begin
                if (if_first && if_req) begin
                    if_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    assign mem_en = h_gnt | d_gnt | if_gnt;
    assign stall  = (if_req & ~if_gnt) | (d_req & ~d_gnt);
    assign rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            case (state)
                ARB:     if (h_gnt && h_lock) state <= LOCKED;
                LOCKED:  if (!h_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            if_rv_q <= 1'b0;
        end else begin
            h_rv_q  <= h_gnt & ~h_we;
            d_rv_q  <= d_gnt & ~d_we;
            if_rv_q <= if_gnt;
        end
    end

    // Masked by rst so a read granted just before reset never reports back.
    assign h_rvalid  = h_rv_q  & ~rst;
    assign d_rvalid  = d_rv_q  & ~rst;
    assign if_rvalid = if_rv_q & ~rst;

endmodule

// File: tb/tb_forth_mem_arbiter.sv
// Bench for forth_mem_arbiter: directed table, hand sequences, then random traffic against a priority model.
module tb_forth_mem_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int SMAX = 4;
`ifdef FORTH_MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic if_req, d_req, d_we, h_req, h_we, h_lock;
    logic [AW-1:0] if_addr, d_addr, h_addr;
    logic [DW-1:0] d_wdata, h_wdata;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid, stall;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    int tests = 0;
    int fails = 0;

    forth_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdata(rdata), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro model: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic hq, hw, dq, dw, iq;
        logic [2:0] g;
        logic st, we;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; d_req = 0; d_we = 0; h_req = 0; h_we = 0; h_lock = 0;
        if_addr = '0; d_addr = '0; h_addr = '0; d_wdata = '0; h_wdata = '0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset, inputs idle.
    task automatic do_reset();
        next_cycle();
        rst = 1;
        clear_inputs();
        next_cycle();
        rst = 0;
    endtask

    // Random-phase model state
    bit m_locked;
    int m_cnt;
    logic [2:0] pend_rv;
    logic m_h, m_d, m_if;
    logic [DW-1:0] exp_d;
    logic exp_we;
    logic [AW-1:0] exp_addr;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i * 37 + 5);
        ram[13'h0010] <= 16'hABCD;
        ram[13'h0100] <= 16'h1234;
        rst = 1;
        clear_inputs();
        mem_rdata = '0;

        vecs[0] = '{hq:0, hw:0, dq:0, dw:0, iq:0, g:3'b000, st:0, we:0};
        vecs[1] = '{hq:0, hw:0, dq:0, dw:0, iq:1, g:3'b001, st:0, we:0};
        vecs[2] = '{hq:0, hw:0, dq:1, dw:0, iq:0, g:3'b010, st:0, we:0};
        vecs[3] = '{hq:0, hw:0, dq:1, dw:1, iq:1, g:3'b010, st:1, we:1};
        vecs[4] = '{hq:1, hw:0, dq:1, dw:1, iq:0, g:3'b100, st:1, we:0};
        vecs[5] = '{hq:1, hw:1, dq:0, dw:0, iq:1, g:3'b100, st:1, we:1};
        vecs[6] = '{hq:1, hw:1, dq:1, dw:0, iq:1, g:3'b100, st:1, we:1};
        vecs[7] = '{hq:0, hw:0, dq:1, dw:0, iq:1, g:3'b010, st:1, we:0};

        // Reset with every requester asserting
        next_cycle();
        rst = 1; if_req = 1; d_req = 1; h_req = 1;
        #4;
        check("rst_gnt", {h_gnt, d_gnt, if_gnt}, 3'b000);
        check("rst_mem_en", mem_en, 0);
        check("rst_stall", stall, 1);
        check("rst_rvalid", {h_rvalid, d_rvalid, if_rvalid}, 3'b000);
        next_cycle();
        rst = 0;
        #4;
        check("post_rst_gnt", {h_gnt, d_gnt, if_gnt}, 3'b100);

        // Fetch read with one-cycle return
        next_cycle();
        clear_inputs();
        if_req = 1; if_addr = 13'h0010;
        #4;
        check("fetch_gnt", {h_gnt, d_gnt, if_gnt}, 3'b001);
        check("fetch_addr", mem_addr, 13'h0010);
        next_cycle();
        if_req = 0;
        #4;
        check("fetch_rvalid", {h_rvalid, d_rvalid, if_rvalid}, 3'b001);
        check("fetch_rdata", rdata, 16'hABCD);

        // Data beats fetch, fetch follows once data lets go
        next_cycle();
        if_req = 1; d_req = 1; d_we = 0; d_addr = 13'h0100;
        #4;
        check("dvi_gnt", {h_gnt, d_gnt, if_gnt}, 3'b010);
        check("dvi_stall", stall, 1);
        next_cycle();
        d_req = 0;
        #4;
        check("dvi_if_gnt", {h_gnt, d_gnt, if_gnt}, 3'b001);
        check("dvi_stall2", stall, 0);
        check("dvi_rvalid", {h_rvalid, d_rvalid, if_rvalid}, 3'b010);
        check("dvi_rdata", rdata, 16'h1234);

        // Host lock holds data off
        do_reset();
        h_req = 1; h_lock = 1; d_req = 1;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("lock_d_gnt", {h_gnt, d_gnt, if_gnt}, 3'b100);
            check("lock_stall", stall, 1);
            next_cycle();
        end
        h_req = 0; h_lock = 0;
        #4;
        check("unlock_d_gnt", {h_gnt, d_gnt, if_gnt}, 3'b010);
        check("unlock_stall", stall, 0);

        // Fetch starvation under continuous data traffic
        do_reset();
        d_req = 1; if_req = 1;
        for (int c = 1; c <= 6; c++) begin
            #4;
            if (FAIR && c == 5) check("starve_gnt", {h_gnt, d_gnt, if_gnt}, 3'b001);
            else                check("starve_gnt", {h_gnt, d_gnt, if_gnt}, 3'b010);
            next_cycle();
        end

        // Lock held with no host request, then reset mid-lock and mid-read
        do_reset();
        h_req = 1; h_lock = 1;
        next_cycle();
        h_req = 0; d_req = 1;
        #4;
        check("locked_idle", {h_gnt, d_gnt, if_gnt}, 3'b000);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        #4;
        check("rst_unlock", {h_gnt, d_gnt, if_gnt}, 3'b010);
        next_cycle();
        rst = 1; d_req = 0;
        #4;
        check("rst_rv_n1", d_rvalid, 0);
        next_cycle();
        rst = 0;
        #4;
        check("rst_rv_n2", d_rvalid, 0);

        // Table of single-cycle arbitration cases from a clean reset
        foreach (vecs[k]) begin
            do_reset();
            h_req = vecs[k].hq; h_we = vecs[k].hw; d_req = vecs[k].dq; d_we = vecs[k].dw;
            if_req = vecs[k].iq; h_lock = 0;
            h_addr = 13'h0aa0; d_addr = 13'h0bb0; d_wdata = 16'h1111; h_wdata = 16'h2222;
            #4;
            check($sformatf("vec%0d_gnt", k), {h_gnt, d_gnt, if_gnt}, vecs[k].g);
            check($sformatf("vec%0d_stall", k), stall, vecs[k].st);
            check($sformatf("vec%0d_en", k), mem_en, |vecs[k].g);
            check($sformatf("vec%0d_we", k), mem_we, vecs[k].we);
        end

        // Random traffic against the priority model
        next_cycle();
        clear_inputs();
        for (int i = 0; i < (1 << AW); i++) shadow[i] = ram[i];
        m_locked = 0; m_cnt = 0; pend_rv = 3'b000;
        exp_q.delete();
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst = (n == 0) || ($urandom_range(0, 59) == 0);
            if (!h_req || m_h) begin
                h_req = ($urandom_range(0, 99) < 25); h_we = $urandom_range(0, 1);
                h_addr = AW'($urandom_range(0, 31)); h_wdata = DW'($urandom);
            end
            if (!d_req || m_d) begin
                d_req = ($urandom_range(0, 99) < 55); d_we = $urandom_range(0, 1);
                d_addr = AW'($urandom_range(0, 31)); d_wdata = DW'($urandom);
            end
            if (!if_req || m_if) begin
                if_req = ($urandom_range(0, 99) < 70);
                if_addr = AW'($urandom_range(0, 31));
            end
            h_lock = ($urandom_range(0, 3) == 0);
            #4;
            // Grant order: reset blocks all; host first; a held lock blocks the rest;
            // a starved fetch (fair build) jumps data; otherwise data then fetch.
            m_h = 0; m_d = 0; m_if = 0;
            if (!rst) begin
                if (h_req) m_h = 1;
                else if (!(m_locked && h_lock)) begin
                    if (FAIR && m_cnt >= SMAX && if_req) m_if = 1;
                    else if (d_req) m_d = 1;
                    else if (if_req) m_if = 1;
                end
            end
            exp_we = m_h ? h_we : (m_d ? d_we : 1'b0);
            exp_addr = m_h ? h_addr : (m_d ? d_addr : if_addr);
            exp_d = m_h ? h_wdata : d_wdata;
            check("rnd_gnt", {h_gnt, d_gnt, if_gnt}, {m_h, m_d, m_if});
            check("rnd_stall", stall, (if_req & ~m_if) | (d_req & ~m_d));
            check("rnd_en_we", {mem_en, mem_we}, {m_h | m_d | m_if, exp_we});
            if (m_h | m_d | m_if) check("rnd_addr", mem_addr, exp_addr);
            if (exp_we) check("rnd_wdata", mem_wdata, exp_d);
            check("rnd_rvalid", {h_rvalid, d_rvalid, if_rvalid}, pend_rv & {3{~rst}});
            if (pend_rv != 3'b000) begin
                if (exp_q.size() == 0) check("rnd_q_empty", 1, 0);
                else begin
                    exp_d = exp_q.pop_front();
                    if (!rst) check("rnd_rdata", rdata, exp_d);
                end
            end
            pend_rv = {m_h & ~h_we, m_d & ~d_we, m_if};
            if (pend_rv != 3'b000) exp_q.push_back(shadow[exp_addr]);
            if (exp_we) shadow[exp_addr] = m_h ? h_wdata : d_wdata;
            if (rst) begin
                m_locked = 0; m_cnt = 0;
            end else begin
                m_locked = h_lock && (m_h || m_locked);
                m_cnt = (!if_req || m_if) ? 0 : ((m_cnt < SMAX) ? m_cnt + 1 : m_cnt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
